// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I fetch stage.
//   fetch_state_t  : fetch FSM states (IDLE, RUN, FAULT)
//   NOP_INSTR      : canonical RV32I NOP (addi x0, x0, 0), used as reset payload
//   word_ofs_w()   : width of a word offset into an instruction memory of a given depth
package rv32i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam int          DEFAULT_MEM_DEPTH = 1024;
  localparam int          WORD_OFS_W        = $clog2(DEFAULT_MEM_DEPTH);

  // Word-offset width for a memory of 'depth' words; never narrower than one bit
  // so slices built from it stay legal for degenerate depths.
  function automatic int word_ofs_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry pipeline register between fetch and decode.
//   clk, rst             : clock, asynchronous active-high reset
//   flush                : drop the held entry (takes priority over a load)
//   in_valid / in_ready  : upstream load request / register can accept this cycle
//   in_pc, in_instr      : payload to capture
//   out_valid / out_ready: downstream handshake; transfer = out_valid & out_ready
//   out_pc, out_instr    : held payload, stable while out_valid & !out_ready
//   transfer             : a downstream transfer completes this cycle
module fetch_buf
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        transfer
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  assign transfer  = valid_q & out_ready;
  // Accept a new entry when empty or when the current one leaves this cycle.
  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
    end else if (flush) begin
      // Payload is left as-is; only the valid bit matters once flushed.
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      pc_q    <= in_pc;
      instr_q <= in_instr;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch stage with combinational instruction memory.
//   clk, rst         : clock, asynchronous active-high reset
//   start            : level; moves the FSM from IDLE to RUN
//   imem_addr        : byte address presented to instruction memory (= pc)
//   imem_instr       : instruction word for imem_addr, same cycle
//   redirect_valid   : taken branch/jump this cycle (honoured only in RUN)
//   redirect_pc      : redirect target byte address
//   out_valid/ready  : handshake towards decode
//   out_pc, out_instr: fetched instruction and its address
//   fault            : sticky fault (misaligned redirect or out-of-range fetch)
//   fetch_count      : number of completed transfers to decode
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam int OFS_W = word_ofs_w(MEM_DEPTH);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         load;
  logic         flush;
  logic         buf_ready;
  logic         transfer;
  logic         in_range;
  logic [29:0]  word_idx;
  logic [OFS_W-1:0] word_ofs;

  assign imem_addr = pc_q;
  assign fault     = (state_q == ST_FAULT);

  // Range check split into "no bits above the offset field" and "offset below
  // depth", which also covers non-power-of-two depths.
  assign word_idx = pc_q[31:2];
  assign word_ofs = word_idx[OFS_W-1:0];
  assign in_range = ((word_idx >> OFS_W) == 30'd0) &&
                    ({{(32-OFS_W){1'b0}}, word_ofs} < 32'(MEM_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          // Target is captured even when misaligned so pc freezes on the
          // offending address; no fetch is latched this cycle.
          flush = 1'b1;
          pc_d  = redirect_pc;
          if (redirect_pc[1:0] != 2'b00) state_d = ST_FAULT;
        end else if (buf_ready) begin
          if (!in_range) begin
            flush   = 1'b1;
            state_d = ST_FAULT;
          end else begin
            load = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
      end
      ST_FAULT: begin
        flush = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A transfer in the same cycle as a flush still completes and is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'h0;
    end else if (transfer && state_q != ST_FAULT) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  fetch_buf u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (load),
    .in_ready  (buf_ready),
    .in_pc     (pc_q),
    .in_instr  (imem_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .transfer  (transfer)
  );

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [DEPTH];

  always #5 clk = ~clk;

  // Combinational instruction memory: word i holds 0xC0DE_0000 + i.
  assign imem_instr = (imem_addr[31:2] < 30'(DEPTH)) ? mem[imem_addr[6:2]] : 32'hDEAD_BEEF;

  instr_fetch #(.RESET_PC(32'h0000_0000), .MEM_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();  // IDLE -> RUN
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", out_pc); end
    checks++; if (out_instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", out_instr); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
  endtask

  task automatic test_idle_redirect();
    rst = 1'b1; tick(); rst = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL idle_redirect_addr: got %h expected 00000000", imem_addr); end
    start = 1'b1;
    tick(); tick();
    checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL idle_redirect_first: got pc %h valid %b expected 00000000 1", out_pc, out_valid); end
  endtask

  task automatic test_sequential();
    restart();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL seq_latency: got valid %b expected 0", out_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4*k) || out_instr !== (32'hC0DE_0000 + 32'(k)))
        begin errors++; $display("FAIL seq_out%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", k, out_valid, out_pc, out_instr, 32'(4*k), 32'hC0DE_0000 + 32'(k)); end
    end
    tick();
    checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL seq_count: got %0d expected 4", fetch_count); end
  endtask

  task automatic test_stall();
    restart();
    start = 1'b0;  // no effect once running
    tick(); tick(); tick();
    checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL stall_setup: got pc %h expected 00000008", out_pc); end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== 32'hC0DE_0002 || imem_addr !== 32'hC)
        begin errors++; $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h addr=%h expected 1 00000008 c0de0002 0000000c", k, out_valid, out_pc, out_instr, imem_addr); end
    end
    checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count: got %0d expected 2", fetch_count); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_pc !== 32'hC || fetch_count !== 32'd3) begin errors++; $display("FAIL stall_release: got pc=%h count=%0d expected 0000000c 3", out_pc, fetch_count); end
  endtask

  task automatic test_redirect();
    restart();
    tick(); tick();
    checks++; if (out_pc !== 32'h4 || fetch_count !== 32'd1) begin errors++; $display("FAIL redir_setup: got pc=%h count=%0d expected 00000004 1", out_pc, fetch_count); end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || fetch_count !== 32'd2) begin errors++; $display("FAIL redir_bubble: got v=%b count=%0d expected 0 2", out_valid, fetch_count); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'hC0DE_0010) begin errors++; $display("FAIL redir_target: got v=%b pc=%h instr=%h expected 1 00000040 c0de0010", out_valid, out_pc, out_instr); end
    tick();
    checks++; if (out_pc !== 32'h44) begin errors++; $display("FAIL redir_next: got %h expected 00000044", out_pc); end
  endtask

  task automatic test_misaligned();
    restart();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b1 || out_valid !== 1'b0 || fetch_count !== 32'd1) begin errors++; $display("FAIL misal_fault: got f=%b v=%b count=%0d expected 1 0 1", fault, out_valid, fetch_count); end
    // Redirects and start are ignored while faulted.
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (fault !== 1'b1 || out_valid !== 1'b0 || fetch_count !== 32'd1 || imem_addr !== 32'h42)
        begin errors++; $display("FAIL misal_hold%0d: got f=%b v=%b count=%0d addr=%h expected 1 0 1 00000042", k, fault, out_valid, fetch_count, imem_addr); end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_range();
    restart();
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      checks++; if (out_pc !== 32'(4*k) || fault !== 1'b0) begin errors++; $display("FAIL range_seq%0d: got pc=%h f=%b expected %h 0", k, out_pc, fault, 32'(4*k)); end
    end
    tick();
    checks++; if (fault !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL range_fault: got f=%b v=%b expected 1 0", fault, out_valid); end
    checks++; if (out_pc !== 32'(4*(DEPTH-1)) || imem_addr !== 32'(4*DEPTH)) begin errors++; $display("FAIL range_last: got pc=%h addr=%h expected %h %h", out_pc, imem_addr, 32'(4*(DEPTH-1)), 32'(4*DEPTH)); end
    checks++; if (fetch_count !== 32'(DEPTH)) begin errors++; $display("FAIL range_count: got %0d expected %0d", fetch_count, DEPTH); end
  endtask

  task automatic test_async_reset();
    restart();
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b1 || fetch_count !== 32'd2) begin errors++; $display("FAIL arst_setup: got v=%b count=%0d expected 1 2", out_valid, fetch_count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0 || fetch_count !== 32'h0 || fault !== 1'b0)
      begin errors++; $display("FAIL arst_now: got v=%b addr=%h count=%0d f=%b expected 0 00000000 0 0", out_valid, imem_addr, fetch_count, fault); end
    start = 1'b0;
    #2 rst = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL arst_idle: got v=%b addr=%h expected 0 00000000", out_valid, imem_addr); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_idle_redirect();
    test_sequential();
    test_stall();
    test_redirect();
    test_misaligned();
    test_range();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after start.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, instruction-memory depth in words, used only for range check.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  level; leaves IDLE when high.
REQ-006 SHALL have port imem_addr  output  32  byte address to the combinational instruction memory.
REQ-007 SHALL have port imem_instr  input  32  instruction word returned the same cycle for imem_addr.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-009 SHALL have port redirect_pc  input  32  target byte address.
REQ-010 SHALL have port out_valid  output  1  fetched instruction available to decode.
REQ-011 SHALL have port out_ready  input  1  decode accepts this cycle.
REQ-012 SHALL have port out_pc  output  32  address of out_instr.
REQ-013 SHALL have port out_instr  output  32  fetched instruction.
REQ-014 SHALL have port fault  output  1  sticky fetch fault (misaligned or out-of-range).
REQ-015 SHALL have port fetch_count  output  32  count of completed out transfers.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FAULT; rst -> IDLE; IDLE->RUN when start=1; RUN->FAULT on fault; FAULT left only by rst.
REQ-017 SHALL drive imem_addr = pc_q combinationally at all times.
REQ-018 SHALL hold one-entry output register {out_pc, out_instr, out_valid}; transfer = out_valid & out_ready.
REQ-019 In RUN, without redirect, SHALL load output register with {pc_q, imem_instr}, set out_valid, pc_q <= pc_q+4 when register empty or transferring; otherwise hold pc_q and register (stall).
REQ-020 Throughput SHALL be one instruction per cycle with out_ready held high; latency pc_q->out_valid one cycle.
REQ-021 out_pc/out_instr SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 redirect_valid in RUN SHALL set pc_q <= redirect_pc, clear out_valid next cycle, latch no fetch that cycle; a same-cycle transfer still completes and counts.
REQ-023 redirect_valid in IDLE or FAULT SHALL be ignored.
REQ-024 redirect_pc[1:0] != 0, or pc word index >= MEM_DEPTH at a fetch attempt, SHALL enter FAULT: fault=1, out_valid=0, pc_q frozen at offending address.
REQ-025 pc_q+4 SHALL wrap modulo 2^32; wrap itself is not a fault unless REQ-024 applies.
REQ-026 fetch_count SHALL increment by 1 per transfer, wrap modulo 2^32, freeze in FAULT.
REQ-027 start deasserting in RUN SHALL have no effect.

Reset
REQ-028 On rst: state=IDLE, pc_q=RESET_PC, out_valid=0, out_pc=0, out_instr=32'h0000_0013 (NOP), fault=0, fetch_count=0.
REQ-029 rst asserted mid-operation SHALL discard the in-flight instruction immediately (asynchronously) with no transfer counted.

Structure
REQ-030 FSM state enum, NOP constant and word-offset width $clog2(MEM_DEPTH) SHALL live in shared package rv32i_pkg.
REQ-031 The output register with handshake SHALL be sub-module fetch_buf (one-entry pipeline register, valid/ready, flush input).

Verification
REQ-032 Reset, start=1, out_ready=1, memory words 0..3 = A,B,C,D -> out_pc 0,4,8,12 on consecutive cycles, fetch_count=4.
REQ-033 out_ready=0 for 3 cycles while out_valid=1 at pc 8 -> out_pc=8 and out_instr stable, imem_addr held at 12.
REQ-034 redirect_valid with redirect_pc=0x40 during transfer of pc 4 -> transfer counted, next cycle out_valid=0, following cycle out_pc=0x40.
REQ-035 redirect_pc=0x42 -> fault=1 next cycle, out_valid=0 forever, fetch_count frozen until rst.
REQ-036 Sequential fetch reaching pc=4*MEM_DEPTH -> fault=1, last out_pc=4*(MEM_DEPTH-1).
REQ-037 rst pulse between clock edges while out_valid=1 -> out_valid=0 immediately, pc=RESET_PC, state IDLE.
